stage2_execute: RTL
===================

Name: stage2_execute

Overview:
- X stage of the 3-stage RV32I pipeline.
- Registers the decoded bundle from Stage1 (D/X register) and executes it: operand bypass, ALU, branch compare, jump/redirect detection, CSR operand selection, data-cache request issue.
- Registers the result into the X/W bundle consumed by Stage3/W, which returns alu_out_w, pc_sel_w, wb_data_w, rwe_w, rd_w.
- Drives jump_x back to Stage1 for the single-slot squash.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_WIDTH, 32, width of the optional redirect counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  freezes both pipeline registers
- pc_d  in  32  PC of the D instruction (Stage1 pc)
- inst_d  in  32  D instruction, already NOP-filtered by Stage1
- rs1d_d, rs2d_d  in  32 each  register-file read data
- imm_d  in  32  immediate
- csrd_d  in  32  CSR read data
- wb_data_w  in  32  W write-back data
- rd_w  in  5  W destination register
- rwe_w  in  1  W register write enable
- jump_x  out  1  X holds a JAL, JALR, or taken branch
- dcache_addr  out  32  word-aligned address ({alu[31:2],2'b00})
- dcache_din  out  32  store data, lane-shifted
- dcache_we  out  4  byte write mask
- dcache_re  out  1  load read enable
- pc_w, inst_w, alu_out_w, csr_wdata_w  out  32 each  X/W registered bundle
- pc_sel_w  out  1  registered redirect
- csr_we_w  out  1  registered CSR write enable
- csr_i_w  out  12  registered CSR index

Behaviour:
- Reset (sync, overrides stall):
  - D/X register: inst=NOP (0x00000013); all other fields 0.
  - X/W register: inst_w=NOP; all other fields 0.
  - Consequently jump_x=0, dcache_we=0, dcache_re=0, pc_sel_w=0, csr_we_w=0.
- Capture:
  - On posedge with !stall && !reset, the D/X register loads the *_d inputs and the X/W register loads the X results.
  - With stall=1 both registers hold, and dcache_we/dcache_re are forced to 0 so a stalled store is not repeated.
- Bypass at capture (register file is not write-through):
  - If rwe_w && rd_w!=0 && rd_w==inst_d[19:15], capture wb_data_w as rs1; same rule for rs2 using inst_d[24:20].
- Bypass in X (combinational):
  - If rwe_w && rd_w!=0 && rd_w matches X rs1 or rs2, that operand uses wb_data_w.
  - x0 is never forwarded.
- ALU:
  - Covers all RV32I ops.
  - Shift amount = operand[4:0].
  - SLT/SLTU are signed/unsigned.
  - LUI result = imm.
  - AUIPC result = pc+imm.
  - JAL/JALR: alu_out = target, with JALR clearing bit 0; the link value pc+4 is carried as pc_w, and W computes it.
- Branch:
  - BEQ/BNE/BLT/BGE/BLTU/BGEU compare the forwarded operands.
  - taken -> jump_x=1.
  - JAL/JALR -> jump_x=1 unconditionally.
  - pc_sel_w <= jump_x at the next capture.
- Store (combinational from X):
  - byte offset = alu[1:0].
  - SB: we=1<<off, din=rs2[7:0] replicated into 4 lanes.
  - SH: off[0]==0 -> we=4'b0011<<off, din={2{rs2[15:0]}}.
  - SW: off==0 -> we=4'b1111.
  - Misaligned SH/SW: we=0 and the store is dropped silently.
- Load:
  - dcache_re=1 for any LOAD opcode.
  - Lane extraction happens in W, using inst_w[14:12] and alu_out_w[1:0].
- CSR:
  - CSRRW: csr_we_w=1, csr_wdata_w=rs1.
  - CSRRWI: csr_we_w=1, csr_wdata_w={27'b0, inst[19:15]}.
  - csr_i_w=inst[31:20].
  - rd receives csrd_d, which is passed through alu_out_w.
- Simultaneous events:
  - stall with W forwarding: the forwarded value is not latched and is re-evaluated each cycle.
  - reset during stall: reset wins.
  - An instruction flushed by Stage1 arrives as NOP and produces no side effects.

Optional Feature:
- Macro: STAGE2_REDIRECT_CNT_EN.
- Defined:
  - Adds outputs br_taken_cnt and jump_cnt (CNT_WIDTH each).
  - On each non-stalled capture, increments br_taken_cnt for a taken branch and jump_cnt for JAL/JALR.
  - Both counters wrap modulo 2^CNT_WIDTH and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- const.vh carries:
  - INSTR_NOP;
  - opcode, funct3 and funct7 defines;
  - ALU select encodings.
- One sub-module, branch_comp: combinational compare of two 32-bit operands plus funct3, producing taken. Everything else stays inline.

Test Plan:
- Reset: hold reset 2 cycles with stall=1 -> inst_w=0x00000013, pc_sel_w=0, dcache_we=0, jump_x=0.
- W->X bypass:
  - X=ADD x3,x1,x2; rwe_w=1, rd_w=1, wb_data_w=5; rs1d=100, rs2d=7 -> alu_out_w=12 after next edge.
  - Repeat with rd_w=0 -> alu_out_w=107.
- Capture bypass: D=ADDI x4,x1,1, rs1d_d=0, W writes x1=0x20 in the same cycle -> next cycle X alu=0x21.
- Branch: BNE with rs1=3, rs2=4, pc=0x100, imm=8 -> jump_x=1 in X; next edge pc_sel_w=1, alu_out_w=0x108. Same with rs1=rs2=4 -> jump_x=0.
- Store lanes:
  - SB rs2=0xAB at addr 0x1003 -> we=4'b1000, din=0xABABABAB, dcache_addr=0x1000.
  - SW at 0x1002 -> we=0.
  - SW with stall=1 -> we=0.
- Counters (STAGE2_REDIRECT_CNT_EN): 3 taken BEQ, 2 JAL, 1 JAL under stall -> br_taken_cnt=3, jump_cnt=2 after stall deasserts and the stalled JAL captures -> jump_cnt=3.

Source files
------------

// File: rtl/stage2_execute_pkg.sv
// Shared constants and types for the X stage of the 3-stage RV32I pipeline.
// Holds the NOP encoding, opcode/funct fields, ALU select encodings and the pipeline bundles.
package stage2_execute_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] csrd;
    } dx_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] aluOut;
        logic [31:0] csrWdata;
        logic        pcSel;
        logic        csrWe;
        logic [11:0] csrIdx;
    } xw_t;

    // alt selects SUB/SRA; callers only raise it where the encoding really carries funct7.
    function automatic alu_sel_e aluSelFromFunct(input logic [2:0] funct3, input logic alt);
        alu_sel_e sel;
        sel = ALU_ADD;
        case (funct3)
            F3_ADD:  sel = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  sel = ALU_SLL;
            F3_SLT:  sel = ALU_SLT;
            F3_SLTU: sel = ALU_SLTU;
            F3_XOR:  sel = ALU_XOR;
            F3_SR:   sel = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   sel = ALU_OR;
            F3_AND:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/stage2_execute_branch_comp.sv
// Branch comparator for the X stage: evaluates the RV32I branch condition
// selected by funct3 on two already-forwarded operands.
module branch_comp
    import stage2_execute_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  funct3_i,
    output logic        taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (a_i == b_i);
            F3_BNE:  taken_o = (a_i != b_i);
            F3_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
            F3_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
            F3_BLTU: taken_o = (a_i <  b_i);
            F3_BGEU: taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/stage2_execute.sv
// X stage of the 3-stage RV32I pipeline: D/X register, operand bypass, ALU, branch/jump
// detection, store/load issue and the X/W register. Optional redirect counters: STAGE2_REDIRECT_CNT_EN.
module stage2_execute
    import stage2_execute_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [XLEN-1:0]      pc_d,
    input  logic [XLEN-1:0]      inst_d,
    input  logic [XLEN-1:0]      rs1d_d,
    input  logic [XLEN-1:0]      rs2d_d,
    input  logic [XLEN-1:0]      imm_d,
    input  logic [XLEN-1:0]      csrd_d,
    input  logic [XLEN-1:0]      wb_data_w,
    input  logic [4:0]           rd_w,
    input  logic                 rwe_w,
    output logic                 jump_x,
    output logic [XLEN-1:0]      dcache_addr,
    output logic [XLEN-1:0]      dcache_din,
    output logic [3:0]           dcache_we,
    output logic                 dcache_re,
    output logic [XLEN-1:0]      pc_w,
    output logic [XLEN-1:0]      inst_w,
    output logic [XLEN-1:0]      alu_out_w,
    output logic [XLEN-1:0]      csr_wdata_w,
    output logic                 pc_sel_w,
    output logic                 csr_we_w,
`ifdef STAGE2_REDIRECT_CNT_EN
    output logic [CNT_WIDTH-1:0] br_taken_cnt,
    output logic [CNT_WIDTH-1:0] jump_cnt,
`endif
    output logic [11:0]          csr_i_w
);

    dx_t dx_q, dx_d;
    xw_t xw_q, xw_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1Idx, rs2Idx;
    logic [31:0] opA, opB;
    logic [31:0] aluA, aluB, aluRes, aluOut;
    alu_sel_e   aluSel;
    logic       brTaken, isBranch, isJump, takenBranch;
    logic [3:0] storeWe;
    logic [31:0] storeDin;
    logic       isCsrWrite;
    logic [31:0] csrWdata;

    // The register file is not write-through, so a same-cycle W write must be caught here.
    always_comb begin
        dx_d      = '0;
        dx_d.pc   = pc_d;
        dx_d.inst = inst_d;
        dx_d.rs1  = (rwe_w && rd_w != 5'd0 && rd_w == inst_d[19:15]) ? wb_data_w : rs1d_d;
        dx_d.rs2  = (rwe_w && rd_w != 5'd0 && rd_w == inst_d[24:20]) ? wb_data_w : rs2d_d;
        dx_d.imm  = imm_d;
        dx_d.csrd = csrd_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q      <= '0;
            dx_q.inst <= INSTR_NOP;
        end else if (!stall) begin
            dx_q <= dx_d;
        end
    end

    assign opcode = dx_q.inst[6:0];
    assign funct3 = dx_q.inst[14:12];
    assign rs1Idx = dx_q.inst[19:15];
    assign rs2Idx = dx_q.inst[24:20];

    // Forwarding is re-evaluated every cycle so a stalled X sees the current W value.
    assign opA = (rwe_w && rd_w != 5'd0 && rd_w == rs1Idx) ? wb_data_w : dx_q.rs1;
    assign opB = (rwe_w && rd_w != 5'd0 && rd_w == rs2Idx) ? wb_data_w : dx_q.rs2;

    always_comb begin
        aluSel = ALU_ADD;
        aluA   = opA;
        aluB   = dx_q.imm;
        case (opcode)
            OPC_OP: begin
                aluSel = aluSelFromFunct(funct3, dx_q.inst[31:25] == F7_ALT);
                aluB   = opB;
            end
            OPC_OPIMM:  aluSel = aluSelFromFunct(funct3, funct3 == F3_SR && dx_q.inst[30]);
            OPC_LUI:    aluSel = ALU_PASSB;
            OPC_AUIPC,
            OPC_JAL,
            OPC_BRANCH: aluA = dx_q.pc;
            OPC_SYSTEM: begin
                aluSel = ALU_PASSB;
                aluB   = dx_q.csrd;
            end
            default: ;
        endcase
    end

    always_comb begin
        aluRes = '0;
        case (aluSel)
            ALU_ADD:   aluRes = aluA + aluB;
            ALU_SUB:   aluRes = aluA - aluB;
            ALU_SLL:   aluRes = aluA << aluB[4:0];
            ALU_SLT:   aluRes = {31'd0, $signed(aluA) < $signed(aluB)};
            ALU_SLTU:  aluRes = {31'd0, aluA < aluB};
            ALU_XOR:   aluRes = aluA ^ aluB;
            ALU_SRL:   aluRes = aluA >> aluB[4:0];
            ALU_SRA:   aluRes = 32'($signed(aluA) >>> aluB[4:0]);
            ALU_OR:    aluRes = aluA | aluB;
            ALU_AND:   aluRes = aluA & aluB;
            ALU_PASSB: aluRes = aluB;
            default:   aluRes = '0;
        endcase
    end

    assign aluOut = (opcode == OPC_JALR) ? {aluRes[31:1], 1'b0} : aluRes;

    branch_comp u_branch_comp (
        .a_i      (opA),
        .b_i      (opB),
        .funct3_i (funct3),
        .taken_o  (brTaken)
    );

    assign isBranch    = (opcode == OPC_BRANCH);
    assign isJump      = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign takenBranch = isBranch && brTaken;
    assign jump_x      = takenBranch || isJump;

    // Misaligned halfword/word stores leave the mask at zero and are silently dropped.
    always_comb begin
        storeWe  = 4'b0000;
        storeDin = opB;
        if (opcode == OPC_STORE) begin
            case (funct3)
                F3_SB: begin
                    storeWe  = 4'b0001 << aluOut[1:0];
                    storeDin = {4{opB[7:0]}};
                end
                F3_SH: begin
                    if (!aluOut[0]) storeWe = 4'b0011 << aluOut[1:0];
                    storeDin = {2{opB[15:0]}};
                end
                F3_SW: begin
                    if (aluOut[1:0] == 2'b00) storeWe = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    assign dcache_addr = {aluOut[31:2], 2'b00};
    assign dcache_din  = storeDin;
    assign dcache_we   = stall ? 4'b0000 : storeWe;
    assign dcache_re   = !stall && (opcode == OPC_LOAD);

    assign isCsrWrite = (opcode == OPC_SYSTEM) && (funct3 == F3_CSRRW || funct3 == F3_CSRRWI);
    assign csrWdata   = funct3[2] ? {27'd0, rs1Idx} : opA;

    always_comb begin
        xw_d          = '0;
        xw_d.pc       = dx_q.pc;
        xw_d.inst     = dx_q.inst;
        xw_d.aluOut   = aluOut;
        xw_d.csrWdata = csrWdata;
        xw_d.pcSel    = jump_x;
        xw_d.csrWe    = isCsrWrite;
        xw_d.csrIdx   = dx_q.inst[31:20];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xw_q      <= '0;
            xw_q.inst <= INSTR_NOP;
        end else if (!stall) begin
            xw_q <= xw_d;
        end
    end

    assign pc_w        = xw_q.pc;
    assign inst_w      = xw_q.inst;
    assign alu_out_w   = xw_q.aluOut;
    assign csr_wdata_w = xw_q.csrWdata;
    assign pc_sel_w    = xw_q.pcSel;
    assign csr_we_w    = xw_q.csrWe;
    assign csr_i_w     = xw_q.csrIdx;

`ifdef STAGE2_REDIRECT_CNT_EN
    logic [CNT_WIDTH-1:0] brCnt_q, jumpCnt_q;

    // Counted at the same capture that moves the redirecting instruction into W.
    always_ff @(posedge clk) begin
        if (reset) begin
            brCnt_q   <= '0;
            jumpCnt_q <= '0;
        end else if (!stall) begin
            if (takenBranch) brCnt_q   <= brCnt_q + 1'b1;
            if (isJump)      jumpCnt_q <= jumpCnt_q + 1'b1;
        end
    end

    assign br_taken_cnt = brCnt_q;
    assign jump_cnt     = jumpCnt_q;
`endif

endmodule
